// File: rtl/io_pkg.sv
// Shared constants and types for the PicoBlaze-successor I/O port decoder.
package io_pkg;

  localparam int IO_ADDR_W = 16;
  localparam int IO_DATA_W = 16;
  localparam int IO_BIT    = 15;

  localparam int PORT_LED  = 0;
  localparam int PORT_SW   = 1;
  localparam int PORT_UART = 7;

  typedef struct packed {
    logic collide;
    logic unmapped;
  } io_err_t;

endpackage

// File: rtl/io_port_dec_if.sv
// Core/peripheral bus seen by the port decoder: address, strobes, enables and read data.
interface io_port_dec_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int NPORTS = 8
);

  logic [ADDR_W-1:0]        port_id;
  logic                     write_strobe;
  logic                     read_strobe;
  logic [NPORTS*DATA_W-1:0] pdata_in;
  logic [NPORTS-1:0]        wr;
  logic [NPORTS-1:0]        rd;
  logic [DATA_W-1:0]        in_port;

  modport master (
    output port_id, write_strobe, read_strobe, pdata_in,
    input  wr, rd, in_port
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, pdata_in,
    output wr, rd, in_port
  );

endinterface

// File: rtl/io_err_log.sv
// Sticky error flags plus capture of the port_id that raised the first error.
module io_err_log
  import io_pkg::*;
#(
  parameter int ADDR_W = IO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  io_err_t           ev,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] port_id,
  output logic              err_unmapped,
  output logic              err_collide,
  output logic [ADDR_W-1:0] err_addr
);

  io_err_t flags;

  // An error in the same cycle as a clear beats the clear and restarts the log.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags    <= '0;
      err_addr <= '0;
    end else if (|ev) begin
      if (err_clr || flags == '0) begin
        err_addr <= port_id;
      end
      flags <= err_clr ? ev : io_err_t'(flags | ev);
    end else if (err_clr) begin
      flags    <= '0;
      err_addr <= '0;
    end
  end

  assign err_unmapped = flags.unmapped;
  assign err_collide  = flags.collide;

endmodule

// File: rtl/io_port_dec.sv
// One-hot port decoder with registered read-data mux and sticky error logging.
module io_port_dec #(
  parameter int ADDR_W  = io_pkg::IO_ADDR_W,
  parameter int DATA_W  = io_pkg::IO_DATA_W,
  parameter int NPORTS  = 8,
  parameter int IO_BIT  = io_pkg::IO_BIT,
  parameter bit STRICT  = 1'b1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  io_port_dec_if.slave      bus,
  input  logic              err_clr,
  output logic              err_unmapped,
  output logic              err_collide,
  output logic [ADDR_W-1:0] err_addr
);

  import io_pkg::*;

  localparam int SEL_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [SEL_W:0] NPORTS_V = (SEL_W + 1)'(NPORTS);

  logic [SEL_W-1:0]  sel;
  logic              io_space;
  logic              in_range;
  logic              high_zero;
  logic              mapped;
  logic              do_wr;
  logic              do_rd;
  logic [NPORTS-1:0] wr_n;
  logic [NPORTS-1:0] rd_n;
  logic [DATA_W-1:0] rdata;
  io_err_t           ev;

  assign sel      = bus.port_id[SEL_W-1:0];
  assign io_space = ~bus.port_id[IO_BIT];
  assign in_range = {1'b0, sel} < NPORTS_V;

  // Bits between the select field and the I/O-space bit; only enforced when strict.
  if (IO_BIT > SEL_W) begin : g_high
    assign high_zero = ~|bus.port_id[IO_BIT-1:SEL_W];
  end else begin : g_nohigh
    assign high_zero = 1'b1;
  end

  assign mapped = io_space & in_range & (high_zero | !STRICT);
  assign do_wr  = bus.write_strobe & ~bus.read_strobe & mapped;
  assign do_rd  = bus.read_strobe & ~bus.write_strobe & mapped;

  always_comb begin
    wr_n  = '0;
    rd_n  = '0;
    rdata = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (sel == SEL_W'(k)) begin
        wr_n[k] = do_wr;
        rd_n[k] = do_rd;
        rdata   = bus.pdata_in[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ev          = '0;
    ev.collide  = bus.write_strobe & bus.read_strobe;
    ev.unmapped = (bus.write_strobe | bus.read_strobe) & ~mapped;
  end

  // Read data follows port_id every cycle so it is ready at the strobe edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.in_port <= '0;
    end else begin
      bus.in_port <= mapped ? rdata : '0;
    end
  end

  if (REG_OUT) begin : g_reg
    logic [NPORTS-1:0] wr_q;
    logic [NPORTS-1:0] rd_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        wr_q <= wr_n;
        rd_q <= rd_n;
      end
    end

    assign bus.wr = wr_q;
    assign bus.rd = rd_q;
  end else begin : g_comb
    assign bus.wr = wr_n;
    assign bus.rd = rd_n;
  end

  io_err_log #(
    .ADDR_W (ADDR_W)
  ) u_err_log (
    .clk          (clk),
    .reset_n      (reset_n),
    .ev           (ev),
    .err_clr      (err_clr),
    .port_id      (bus.port_id),
    .err_unmapped (err_unmapped),
    .err_collide  (err_collide),
    .err_addr     (err_addr)
  );

endmodule

// File: tb/tb_io_port_dec.sv
// Directed bench: dut_a is strict/registered, dut_b is aliasing/combinational, same stimulus.
module tb_io_port_dec;

  import io_pkg::*;

  localparam int NP = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic err_clr;

  logic               a_err_unmapped, a_err_collide;
  logic [IO_ADDR_W-1:0] a_err_addr;
  logic               b_err_unmapped, b_err_collide;
  logic [IO_ADDR_W-1:0] b_err_addr;

  int vectors     = 0;
  int miscompares = 0;

  io_port_dec_if #(.ADDR_W(IO_ADDR_W), .DATA_W(IO_DATA_W), .NPORTS(NP)) bus_a ();
  io_port_dec_if #(.ADDR_W(IO_ADDR_W), .DATA_W(IO_DATA_W), .NPORTS(NP)) bus_b ();

  assign bus_b.port_id      = bus_a.port_id;
  assign bus_b.write_strobe = bus_a.write_strobe;
  assign bus_b.read_strobe  = bus_a.read_strobe;
  assign bus_b.pdata_in     = bus_a.pdata_in;

  always #5 clk = ~clk;

  io_port_dec #(
    .ADDR_W (IO_ADDR_W), .DATA_W (IO_DATA_W), .NPORTS (NP),
    .IO_BIT (IO_BIT), .STRICT (1'b1), .REG_OUT (1'b1)
  ) dut_a (
    .clk (clk), .reset_n (reset_n), .bus (bus_a), .err_clr (err_clr),
    .err_unmapped (a_err_unmapped), .err_collide (a_err_collide), .err_addr (a_err_addr)
  );

  io_port_dec #(
    .ADDR_W (IO_ADDR_W), .DATA_W (IO_DATA_W), .NPORTS (NP),
    .IO_BIT (IO_BIT), .STRICT (1'b0), .REG_OUT (1'b0)
  ) dut_b (
    .clk (clk), .reset_n (reset_n), .bus (bus_b), .err_clr (err_clr),
    .err_unmapped (b_err_unmapped), .err_collide (b_err_collide), .err_addr (b_err_addr)
  );

  task automatic applyStimulus(input logic [IO_ADDR_W-1:0] pid, input logic ws,
                               input logic rs, input logic clr);
    @(negedge clk);
    bus_a.port_id      = pid;
    bus_a.write_strobe = ws;
    bus_a.read_strobe  = rs;
    err_clr            = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic postEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n            = 1'b0;
    err_clr            = 1'b0;
    bus_a.port_id      = '0;
    bus_a.write_strobe = 1'b0;
    bus_a.read_strobe  = 1'b0;
    for (int k = 0; k < NP; k++) begin
      bus_a.pdata_in[k*IO_DATA_W +: IO_DATA_W] = 16'hA000 + 16'(k);
    end
    bus_a.pdata_in[5*IO_DATA_W +: IO_DATA_W] = 16'hBEEF;

    repeat (2) @(negedge clk);
    checkOutput("reset_wr",       64'(bus_a.wr),       64'h0);
    checkOutput("reset_rd",       64'(bus_a.rd),       64'h0);
    checkOutput("reset_in_port",  64'(bus_a.in_port),  64'h0);
    checkOutput("reset_unmapped", 64'(a_err_unmapped), 64'h0);
    checkOutput("reset_collide",  64'(a_err_collide),  64'h0);
    checkOutput("reset_err_addr", 64'(a_err_addr),     64'h0);
    reset_n = 1'b1;

    // Mapped write to port 3
    applyStimulus(16'h0003, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("b_wr3_comb", 64'(bus_b.wr), 64'h08);
    postEdge();
    checkOutput("a_wr3",         64'(bus_a.wr),       64'h08);
    checkOutput("a_wr3_rd",      64'(bus_a.rd),       64'h00);
    checkOutput("a_wr3_in_port", 64'(bus_a.in_port),  64'hA003);
    checkOutput("a_wr3_noerr",   64'(a_err_unmapped), 64'h0);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    postEdge();
    checkOutput("a_wr3_width", 64'(bus_a.wr), 64'h00);

    // Highest port
    applyStimulus(IO_ADDR_W'(PORT_UART), 1'b1, 1'b0, 1'b0);
    #1 checkOutput("b_wr7_comb", 64'(bus_b.wr), 64'h80);
    postEdge();
    checkOutput("a_wr7", 64'(bus_a.wr), 64'h80);

    // Read mux, address held a cycle before the strobe
    applyStimulus(16'h0005, 1'b0, 1'b0, 1'b0);
    postEdge();
    checkOutput("a_rd5_early", 64'(bus_a.in_port), 64'hBEEF);
    checkOutput("a_rd5_early_rd", 64'(bus_a.rd),   64'h00);
    applyStimulus(16'h0005, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("b_rd5_comb", 64'(bus_b.rd), 64'h20);
    postEdge();
    checkOutput("a_rd5",         64'(bus_a.rd),      64'h20);
    checkOutput("a_rd5_in_port", 64'(bus_a.in_port), 64'hBEEF);
    applyStimulus(IO_ADDR_W'(PORT_LED), 1'b0, 1'b0, 1'b0);
    postEdge();
    checkOutput("a_rd5_width",   64'(bus_a.rd),      64'h00);
    checkOutput("a_in_port_led", 64'(bus_a.in_port), 64'hA000);

    // Alias: unmapped when strict, port 3 when aliasing
    applyStimulus(16'h0013, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("b_alias_wr", 64'(bus_b.wr), 64'h08);
    postEdge();
    checkOutput("a_alias_wr",       64'(bus_a.wr),       64'h00);
    checkOutput("a_alias_unmapped", 64'(a_err_unmapped), 64'h1);
    checkOutput("a_alias_addr",     64'(a_err_addr),     64'h0013);
    checkOutput("a_alias_in_port",  64'(bus_a.in_port),  64'h0);
    checkOutput("b_alias_unmapped", 64'(b_err_unmapped), 64'h0);
    checkOutput("b_alias_addr",     64'(b_err_addr),     64'h0);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);
    postEdge();
    checkOutput("a_clr_unmapped", 64'(a_err_unmapped), 64'h0);
    checkOutput("a_clr_addr",     64'(a_err_addr),     64'h0);

    // I/O-space bit set
    applyStimulus(16'h8002, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("b_io_rd", 64'(bus_b.rd), 64'h00);
    postEdge();
    checkOutput("a_io_rd",       64'(bus_a.rd),       64'h00);
    checkOutput("a_io_in_port",  64'(bus_a.in_port),  64'h0);
    checkOutput("a_io_unmapped", 64'(a_err_unmapped), 64'h1);
    checkOutput("a_io_addr",     64'(a_err_addr),     64'h8002);
    checkOutput("b_io_unmapped", 64'(b_err_unmapped), 64'h1);

    // Collision keeps the first error address
    applyStimulus(16'h0001, 1'b1, 1'b1, 1'b0);
    #1 checkOutput("b_col_wrrd", 64'({bus_b.wr, bus_b.rd}), 64'h0);
    postEdge();
    checkOutput("a_col_wrrd",     64'({bus_a.wr, bus_a.rd}), 64'h0);
    checkOutput("a_col_collide",  64'(a_err_collide),  64'h1);
    checkOutput("a_col_unmapped", 64'(a_err_unmapped), 64'h1);
    checkOutput("a_col_addr",     64'(a_err_addr),     64'h8002);
    checkOutput("a_col_in_port",  64'(bus_a.in_port),  64'hA001);

    // Error and clear together: error wins and reloads the address
    applyStimulus(16'h0100, 1'b0, 1'b1, 1'b1);
    #1 checkOutput("b_clrerr_rd", 64'(bus_b.rd), 64'h01);
    postEdge();
    checkOutput("a_clrerr_unmapped", 64'(a_err_unmapped), 64'h1);
    checkOutput("a_clrerr_collide",  64'(a_err_collide),  64'h0);
    checkOutput("a_clrerr_addr",     64'(a_err_addr),     64'h0100);
    checkOutput("b_clrerr_flags",    64'({b_err_collide, b_err_unmapped}), 64'h0);
    checkOutput("b_clrerr_addr",     64'(b_err_addr),     64'h0);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);
    postEdge();
    checkOutput("a_clr2_flags", 64'({a_err_collide, a_err_unmapped}), 64'h0);
    checkOutput("a_clr2_addr",  64'(a_err_addr), 64'h0);

    // Async reset between the strobe edge and the next edge
    applyStimulus(16'h8004, 1'b1, 1'b0, 1'b0);
    postEdge();
    checkOutput("a_pre_unmapped", 64'(a_err_unmapped), 64'h1);
    applyStimulus(16'h0002, 1'b1, 1'b0, 1'b0);
    postEdge();
    checkOutput("a_pre_wr",      64'(bus_a.wr),      64'h04);
    checkOutput("a_pre_in_port", 64'(bus_a.in_port), 64'hA002);
    checkOutput("a_pre_addr",    64'(a_err_addr),    64'h8004);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("a_rst_wr",      64'(bus_a.wr),      64'h00);
    checkOutput("a_rst_in_port", 64'(bus_a.in_port), 64'h0);
    checkOutput("a_rst_flags",   64'({a_err_collide, a_err_unmapped}), 64'h0);
    checkOutput("a_rst_addr",    64'(a_err_addr),    64'h0);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    postEdge();
    checkOutput("a_post_wrrd",    64'({bus_a.wr, bus_a.rd}), 64'h0);
    checkOutput("a_post_in_port", 64'(bus_a.in_port), 64'hA000);
    checkOutput("a_post_flags",   64'({a_err_collide, a_err_unmapped}), 64'h0);
    postEdge();
    checkOutput("a_post2_wrrd", 64'({bus_a.wr, bus_a.rd}), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_port_dec.md
Name: io_port_dec

Overview:
- Parametrised successor to the PicoBlaze I/O port decoder; sits between the emulated PicoBlaze core and its peripherals.
- Decodes port_id plus write_strobe/read_strobe into one-hot per-port write/read enables.
- Returns a registered read-data word to the core from the selected peripheral.
- Adds over the previous generation: configurable port count, widths and I/O-space bit; optional registered strobes; strict (non-aliasing) decode; sticky error capture for unmapped and colliding accesses.

Parameters:
- ADDR_W, 16, port_id width.
- DATA_W, 16, peripheral/core data width.
- NPORTS, 8, number of decoded ports, 2..64; SEL_W = max(1, clog2(NPORTS)) is a derived localparam.
- IO_BIT, 15, port_id bit that must be 0 for an I/O-space access; must be ≥ SEL_W.
- STRICT, 1:
  - 1: port_id[IO_BIT-1:SEL_W] must be all zero, else the access is unmapped.
  - 0: those bits are ignored (aliasing).
- REG_OUT, 1: 1 = wr/rd registered (1-cycle latency); 0 = wr/rd combinational.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- port_id  in  ADDR_W  port address from core.
- write_strobe  in  1  core write strobe.
- read_strobe  in  1  core read strobe.
- pdata_in  in  NPORTS*DATA_W  concatenated peripheral read data; port k occupies [k*DATA_W +: DATA_W].
- err_clr  in  1  clears sticky error flags and err_addr.
- wr  out  NPORTS  one-hot write enables.
- rd  out  NPORTS  one-hot read enables.
- in_port  out  DATA_W  registered read data to core.
- err_unmapped  out  1  sticky: strobe to unmapped address.
- err_collide  out  1  sticky: write_strobe and read_strobe asserted together.
- err_addr  out  ADDR_W  port_id of the first error since the last clear.

Behaviour:
- Reset (reset_n low, async): wr, rd, in_port, err_unmapped, err_collide and err_addr all 0. Reset asserted mid-access drops any strobe in flight; no output pulse follows reset release.
- sel = port_id[SEL_W-1:0].
- mapped is true only when all of the following hold:
  - port_id[IO_BIT] == 0;
  - sel < NPORTS;
  - when STRICT=1, port_id[IO_BIT-1:SEL_W] == 0.
- Decode, cycle t:
  - wr_n[sel] = write_strobe & mapped & ~read_strobe; all other bits 0.
  - rd_n[sel] = read_strobe & mapped & ~write_strobe; all other bits 0.
- Output timing:
  - REG_OUT=1: wr/rd = wr_n/rd_n registered, visible in cycle t+1, exactly one cycle wide per strobe cycle.
  - REG_OUT=0: wr/rd = wr_n/rd_n, same cycle.
- Back-to-back strobes on consecutive cycles yield consecutive pulses. wr and rd are never both nonzero and never more than one bit set.
- Read data: in_port is updated every cycle.
  - mapped: in_port <= pdata_in[sel*DATA_W +: DATA_W].
  - not mapped: in_port <= 0.
  - Latency is 1 cycle. The core holds port_id stable before read_strobe, so data is valid at the strobe edge.
- Collision (write_strobe & read_strobe): no wr/rd bit asserts; err_collide <= 1.
- Unmapped strobe (one strobe asserted, mapped false): no wr/rd bit asserts; err_unmapped <= 1.
- A cycle with both strobes and an unmapped address sets both flags.
- err_addr capture: loads port_id on the first error cycle while both flags are 0. Later errors do not overwrite it until a clear.
- err_clr: flags and err_addr <= 0 next edge. If an error event and err_clr occur in the same cycle, the error wins: the flag is set and err_addr is reloaded with the current port_id.
- No strobe: no state change except in_port.

Decomposition:
- Shared package io_pkg:
  - IO_ADDR_W = 16, IO_DATA_W = 16, IO_BIT = 15.
  - Port-number constants for the LED, switch and UART peripherals.
  - io_err_t, a 2-bit typedef {collide, unmapped}.
- One sub-module: io_err_log (sticky flags + err_addr capture/clear).
- Decode and the read mux stay in io_port_dec.

Test Plan:
- Mapped write, REG_OUT=1, NPORTS=8: port_id=16'h0003, write_strobe=1 for 1 cycle -> wr=8'b0000_1000 exactly in the next cycle; rd=0; no error.
- Read mux: pdata_in slot 5 = 16'hBEEF, port_id=16'h0005 held 2 cycles, read_strobe in the 2nd cycle -> in_port=16'hBEEF at the strobe edge; rd[5] one cycle later.
- Strict alias: port_id=16'h0013, write_strobe -> wr=0, err_unmapped=1, err_addr=16'h0013. Same stimulus with STRICT=0 -> wr[3]=1, no error.
- I/O-space bit and collision:
  - port_id=16'h8002, read_strobe -> rd=0, in_port=0, err_unmapped=1.
  - Then port_id=16'h0001 with both strobes -> wr=rd=0, err_collide=1, err_addr still 16'h8002.
- err_clr with simultaneous unmapped strobe at port_id=16'h0100 -> flag stays 1, err_addr=16'h0100. err_clr alone next cycle -> all error outputs 0.
- Async reset mid-access: assert reset_n=0 between the strobe edge and the output edge with REG_OUT=1 -> wr/rd/in_port/errors all 0 immediately; no pulse after release.
